// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM states, PC step and default reset vector.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer holding {pc, instr}; flush overrides push and pop.
module fetch_buffer #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_pc,
    input  logic [Width-1:0] push_instr,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic [Width-1:0] head_pc,
    output logic [Width-1:0] head_instr
);
    logic [1:0]       count_q, count_d;
    logic [Width-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [Width-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic             do_pop, do_push, fill_slot0;

    always_comb begin
        count_d  = count_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        // Slot 0 receives the new entry when it is (or becomes) free this cycle.
        fill_slot0 = (count_q == 2'd0) || ((count_q == 2'd1) && do_pop);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                pc0_d    = pc1_q;
                instr0_d = instr1_q;
            end
            if (do_push) begin
                if (fill_slot0) begin
                    pc0_d    = push_pc;
                    instr0_d = push_instr;
                end else begin
                    pc1_d    = push_pc;
                    instr1_d = push_instr;
                end
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            instr0_q <= '0;
            instr1_q <= '0;
        end else begin
            count_q  <= count_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
        end
    end

    assign count      = count_q;
    assign head_pc    = pc0_q;
    assign head_instr = instr0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request feeding a 2-entry buffer.
// Define FETCH_PERF_EN to add the stall_cycles / flush_count counters.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int               Width    = 32,
    parameter logic [Width-1:0] RESET_PC = Width'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [Width-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [Width-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [Width-1:0] redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [Width-1:0] id_instr,
    output logic [Width-1:0] id_pc,
`ifdef FETCH_PERF_EN
    output logic [Width-1:0] stall_cycles,
    output logic [Width-1:0] flush_count,
`endif
    output fetch_state_e     dbg_state
);
    // Handshakes: a request transfers when imem_req_valid && imem_req_ready, and an
    // instruction leaves when id_valid && id_ready; valid never waits on ready.
    fetch_state_e     state_q, state_d;
    logic [Width-1:0] pc_q, pc_d;
    logic [Width-1:0] redirect_target, buf_push_pc;
    logic [1:0]       buf_count;
    logic             buf_push, buf_flush, buf_pop, req_fire;

    assign redirect_target = redirect_pc & ~Width'(3);
    assign imem_req_valid  = !rst && (state_q == RUN) && (buf_count < 2'd2) && !redirect_valid;
    assign imem_addr       = pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign id_valid        = (buf_count != 2'd0);
    assign buf_pop         = id_valid && id_ready;
    // While a request is outstanding pc_q already points one word past it.
    assign buf_push_pc     = pc_q - Width'(PC_INCR);
    assign dbg_state       = state_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_push  = 1'b0;
        buf_flush = 1'b0;
        if (redirect_valid) begin
            buf_flush = 1'b1;
            pc_d      = redirect_target;
        end
        case (state_q)
            RUN: begin
                if (req_fire) begin
                    pc_d    = pc_q + Width'(PC_INCR);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d  = RUN;
                    buf_push = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer #(.Width(Width)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .push_pc    (buf_push_pc),
        .push_instr (imem_rsp_data),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .count      (buf_count),
        .head_pc    (id_pc),
        .head_instr (id_instr)
    );

`ifdef FETCH_PERF_EN
    logic [Width-1:0] stall_q, stall_d, flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!id_valid && (stall_q != '1)) stall_d = stall_q + Width'(1);
        if (redirect_valid && (flush_q != '1)) flush_d = flush_q + Width'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset and counter sequences,
// then randomized memory/decode traffic checked against a queue-based model.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         imem_req_ready, imem_rsp_valid, redirect_valid, id_ready;
    logic [W-1:0] imem_rsp_data, redirect_pc;
    logic         imem_req_valid, id_valid;
    logic [W-1:0] imem_addr, id_instr, id_pc;
    fetch_state_e dbg_state;
    logic         w_req_valid, w_id_valid;
    logic [W-1:0] w_addr, w_instr, w_pc;
    fetch_state_e w_state;
`ifdef FETCH_PERF_EN
    logic [W-1:0] stall_cycles, flush_count, w_stall, w_flush;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_pc, m_req_pc;
    logic           m_out, m_stale;
    // Memory responder state
    logic           mem_busy;
    logic [W-1:0]   mem_addr;
    int             mem_cnt;

    typedef struct {
        logic         idr, rr, rv, rd;
        logic [W-1:0] raddr, rpc;
        logic         e_rv;
        logic [W-1:0] e_addr;
        logic         e_iv;
        logic [W-1:0] e_pc;
        fetch_state_e e_st;
        logic         chk_w;
        logic [W-1:0] e_waddr;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_unit #(.Width(W), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
`ifdef FETCH_PERF_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .dbg_state(dbg_state)
    );

    fetch_unit #(.Width(W), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(w_id_valid), .id_ready(id_ready), .id_instr(w_instr), .id_pc(w_pc),
`ifdef FETCH_PERF_EN
        .stall_cycles(w_stall), .flush_count(w_flush),
`endif
        .dbg_state(w_state)
    );

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic vec_t mk(input logic idr, rr, rv, rd, input logic [W-1:0] raddr, rpc,
                                input logic e_rv, input logic [W-1:0] e_addr,
                                input logic e_iv, input logic [W-1:0] e_pc,
                                input fetch_state_e e_st, input logic chk_w,
                                input logic [W-1:0] e_waddr);
        vec_t v;
        v.idr = idr; v.rr = rr; v.rv = rv; v.rd = rd; v.raddr = raddr; v.rpc = rpc;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
        v.e_st = e_st; v.chk_w = chk_w; v.e_waddr = e_waddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic idr, rr, rv, rd, input logic [W-1:0] raddr, rpc);
        id_ready       = idr;
        imem_req_ready = rr;
        imem_rsp_valid = rv;
        redirect_valid = rd;
        imem_rsp_data  = mem_word(raddr);
        redirect_pc    = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic model_step(input logic idr, rr, rv, rd, input logic [W-1:0] rdata, rpc);
        logic e_rv;
        e_rv = !m_out && (exp_q.size() < 2) && !rd;
        if (rd) begin
            exp_q.delete();
            m_pc = rpc & ~32'h3;
            if (m_out) begin
                if (rv) begin m_out = 1'b0; m_stale = 1'b0; end
                else m_stale = 1'b1;
            end
        end else begin
            if (idr && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_out && rv) begin
                if (!m_stale) exp_q.push_back({m_req_pc, rdata});
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (e_rv && rr) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_out    = 1'b1;
            end
        end
    endtask

    initial begin
        logic         idr, rr, rv, rd, e_rv;
        logic [W-1:0] rpc;
        logic [2*W-1:0] head;

        //            idr rr rv rd raddr        rpc          e_rv e_addr       e_iv e_pc        st     cw waddr
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,   32'h0,   1, 32'h0,   0, 32'h0,   RUN,   1, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h0,   WAIT,  0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,   32'h0,   1, 32'h4,   1, 32'h0,   RUN,   1, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h4,   32'h0,   0, 32'h0,   0, 32'h0,   WAIT,  0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,   32'h0,   1, 32'h8,   1, 32'h4,   RUN,   1, 32'h4));
        vecs.push_back(mk(1, 0, 1, 0, 32'h8,   32'h0,   0, 32'h0,   0, 32'h0,   WAIT,  0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hC,   1, 32'h8,   RUN,   0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 32'hC,   0, 32'h0,   RUN,   0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'hC,   32'h0,   0, 32'h0,   0, 32'h0,   WAIT,  0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 32'h10,  1, 32'hC,   RUN,   0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h10,  32'h0,   0, 32'h0,   1, 32'hC,   WAIT,  0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,   0, 32'h0,   1, 32'hC,   RUN,   0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,   32'h0,   0, 32'h0,   1, 32'hC,   RUN,   0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'h14,  1, 32'h10,  RUN,   0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h40,  32'h0,   1, 32'h14,  0, 32'h0,   RUN,   0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,   32'h0,   1, 32'h14,  0, 32'h0,   RUN,   0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h0,   32'h103, 0, 32'h0,   0, 32'h0,   WAIT,  0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h14,  32'h0,   0, 32'h0,   0, 32'h0,   DRAIN, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 32'h100, 0, 32'h0,   RUN,   0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h100, 32'h0,   0, 32'h0,   0, 32'h0,   WAIT,  0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 32'h104, 1, 32'h100, RUN,   0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 1, 32'h104, 32'h200, 0, 32'h0,   1, 32'h100, WAIT,  0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h0,   RUN,   0, 32'h0));

        // Reset with every other input asserted
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        drive(1, 1, 1, 1, 32'h44, 32'h88);
        tick();
        settle();
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(RUN));
        check("rst_w_req_valid", 32'(w_req_valid), 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].idr, vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].raddr, vecs[i].rpc);
            settle();
            check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_id_valid", i), 32'(id_valid), 32'(vecs[i].e_iv));
            if (vecs[i].e_iv) begin
                check($sformatf("v%0d_id_pc", i), id_pc, vecs[i].e_pc);
                check($sformatf("v%0d_id_instr", i), id_instr, mem_word(vecs[i].e_pc));
            end
            check($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_st));
            if (vecs[i].chk_w) check($sformatf("v%0d_wrap_addr", i), w_addr, vecs[i].e_waddr);
            tick();
        end

        // Reset while a request is outstanding: nothing of it may survive
        drive(0, 1, 0, 0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        settle();
        check("ro_state", 32'(dbg_state), 32'(RUN));
        check("ro_req_valid_in_rst", 32'(imem_req_valid), 32'h0);
        check("ro_id_valid", 32'(id_valid), 32'h0);
        rst = 1'b0;
        settle();
        check("ro_req_valid", 32'(imem_req_valid), 32'h1);
        check("ro_addr", imem_addr, 32'h0);
        check("ro_w_addr", w_addr, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0, 32'h0, 32'h0);
        tick();
        drive(1, 0, 1, 0, 32'h0, 32'h0);
        tick();
        settle();
        check("ro_id_valid_after", 32'(id_valid), 32'h1);
        check("ro_id_pc_after", id_pc, 32'h0);
        check("ro_id_instr_after", id_instr, mem_word(32'h0));
        drive(0, 0, 0, 0, 32'h0, 32'h0);

`ifdef FETCH_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 32'h0, 32'h300);
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        settle();
        check("perf_flush_count", flush_count, 32'd3);
        check("perf_stall_cycles", stall_cycles, 32'd3);
        rst = 1'b1;
        tick();
        settle();
        check("perf_flush_rst", flush_count, 32'd0);
        check("perf_stall_rst", stall_cycles, 32'd0);
`endif

        // Randomized traffic against the reference model
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        m_pc = 32'h0; m_req_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0;
        mem_busy = 1'b0; mem_addr = 32'h0; mem_cnt = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            idr = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            rv  = mem_busy && (mem_cnt == 0);
            drive(idr, rr, rv, rd, mem_addr, rpc);
            settle();
            e_rv = !m_out && (exp_q.size() < 2) && !rd;
            check($sformatf("rnd%0d_req_valid", cyc), 32'(imem_req_valid), 32'(e_rv));
            if (e_rv) check($sformatf("rnd%0d_addr", cyc), imem_addr, m_pc);
            check($sformatf("rnd%0d_id_valid", cyc), 32'(id_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                check($sformatf("rnd%0d_id_pc", cyc), id_pc, head[2*W-1:W]);
                check($sformatf("rnd%0d_id_instr", cyc), id_instr, head[W-1:0]);
            end
            if (rv) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (imem_req_valid && rr) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = $urandom_range(0, 2);
            end
            model_step(idr, rr, rv, rd, imem_rsp_data, rpc);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter Width, default 32, meaning data/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port imem_req_valid, output, 1, meaning a fetch request is presented.
REQ-006 SHALL have port imem_req_ready, input, 1, meaning memory accepts the request this cycle.
REQ-007 SHALL have port imem_addr, output, Width, meaning the fetch address, word-aligned.
REQ-008 SHALL have port imem_rsp_valid, input, 1, meaning the instruction word is returned this cycle.
REQ-009 SHALL have port imem_rsp_data, input, Width, meaning the returned instruction word.
REQ-010 SHALL have port redirect_valid, input, 1, meaning a taken branch/jal/jalr redirect.
REQ-011 SHALL have port redirect_pc, input, Width, meaning the redirect target.
REQ-012 SHALL have port id_valid, output, 1, meaning id_instr/id_pc hold a valid instruction for decode.
REQ-013 SHALL have port id_ready, input, 1, meaning decode (immediate extension stage) consumes this cycle.
REQ-014 SHALL have port id_instr, output, Width, meaning the instruction word fed to decode/immediate extension.
REQ-015 SHALL have port id_pc, output, Width, meaning the PC of id_instr.

Function
REQ-016 SHALL keep a fetch PC; each accepted request (imem_req_valid and imem_req_ready) advances it by 4, wrapping modulo 2^Width.
REQ-017 SHALL allow at most one outstanding request; responses are in order, arriving one or more cycles after acceptance.
REQ-018 SHALL use FSM states RUN (may issue), WAIT (one request outstanding), DRAIN (outstanding response to be discarded).
REQ-019 SHALL raise imem_req_valid only in RUN, only when buffer occupancy is below 2, and only when redirect_valid is low; once raised, it and imem_addr SHALL hold until accepted, unless a redirect occurs.
REQ-020 SHALL transition RUN->WAIT on acceptance, and WAIT->RUN on imem_rsp_valid, writing {pc, imem_rsp_data} into a 2-entry in-order buffer.
REQ-021 SHALL drive id_valid whenever the buffer is non-empty, with id_instr/id_pc taken from the head entry; the head is popped when id_valid and id_ready are both high.
REQ-022 SHALL, on redirect_valid, flush the buffer, drop id_valid the next cycle, and load the fetch PC with {redirect_pc[Width-1:2], 2'b00}.
REQ-023 SHALL move WAIT->DRAIN on a redirect; in DRAIN the next response is discarded, and the FSM then returns to RUN.
REQ-024 SHALL handle a redirect coinciding with a response in WAIT by discarding that response and going to RUN.
REQ-025 SHALL give redirect priority over pop and push when they occur in the same cycle; a simultaneous pop and push with the buffer full SHALL keep occupancy at 2 with no loss.
REQ-026 SHALL ignore imem_rsp_valid in RUN, as a protocol error with no state change.
REQ-027 SHALL have a best-case latency from request acceptance to id_valid of response latency + 1 cycle.

Reset
REQ-028 SHALL, with rst high at a clock edge, set PC=RESET_PC, FSM=RUN, buffer empty, id_valid=0, imem_req_valid=0, id_instr=0, id_pc=0; reset SHALL win over every other input.
REQ-029 SHALL, when reset is asserted while a request is outstanding, leave no memory of it; the integration SHALL hold memory in reset alongside this block.

Configuration
REQ-030 SHALL, with FETCH_PERF_EN defined, add output ports stall_cycles (Width) counting cycles with id_valid=0 outside reset, and flush_count (Width) counting redirects; both saturate at all-ones and reset to 0.
REQ-031 SHALL, without FETCH_PERF_EN, have neither the ports nor the counters, with functional behaviour otherwise identical.

Structure
REQ-032 SHALL place the FSM state typedef (RUN/WAIT/DRAIN), the PC increment constant 4, and the default RESET_PC in the shared package riscv_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module fetch_buffer (push, pop, flush, count, head outputs).

Verification
REQ-034 SHALL check reset then zero-wait memory: first imem_addr=0x0, then 0x4, 0x8; id_pc sequence 0x0,0x4,0x8 with matching id_instr.
REQ-035 SHALL check backpressure: with id_ready=0, at most 2 responses are buffered and imem_req_valid is low; releasing id_ready drains in order with no loss.
REQ-036 SHALL check a redirect to 0x103 while a request is outstanding: the stale response is discarded, the next imem_addr is 0x100, and id_pc is 0x100.
REQ-037 SHALL check redirect plus response plus pop in the same cycle: the buffer is empty next cycle, id_valid=0, and the FSM is in RUN.
REQ-038 SHALL check the PC wrap: RESET_PC=0xFFFF_FFFC gives fetches at 0xFFFF_FFFC then 0x0000_0000.
REQ-039 SHALL, with FETCH_PERF_EN, check that 3 redirects give flush_count=3, and that reset mid-run clears both counters.
